instruction_prefetch: RTL and testbench

- Parametrised successor to the single-slot fetch stage: decouples the instruction memory from decode with a QDEPTH-entry in-order fetch queue.
- Keeps up to QDEPTH requests in flight across a valid/ready memory interface, so memory latency is hidden. Stall-cause inputs are replaced by a backpressure handshake on the output.
- Supports redirect (branch/jump/trap) with a full flush and discard of in-flight responses.
- Sits between the core's PC-redirect logic and the decode stage.

---
 rtl/instruction_prefetch_if.sv | 41 ++++
 rtl/instruction_prefetch.sv | 179 +++++++++++++++++
 tb/tb_instruction_prefetch.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_prefetch_if.sv
// Fetch-stage bus bundle: instruction-memory request/response channel plus the
// decode-facing output channel. master = prefetcher side, slave = memory/decode side.
interface instruction_prefetch_if #(
  parameter int unsigned XLEN = 32
);

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [31:0]     out_insn;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data,
    output out_valid,
    output out_pc,
    output out_insn,
    input  out_ready
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data,
    input  out_valid,
    input  out_pc,
    input  out_insn,
    output out_ready
  );

endinterface

// File: rtl/instruction_prefetch.sv
// Instruction prefetch unit: keeps up to QDEPTH fetches in flight and buffers
// returned instructions in an in-order queue in front of decode. Redirects
// flush the queue and discard responses still in flight.
// Optional macro IFETCH_STATS_EN adds saturating fetch/drop statistic counters.
module instruction_prefetch #(
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] START_ADDR = XLEN'(32'h8000_0000),
  parameter int unsigned     QDEPTH     = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         run,
  input  logic                         redirect_en,
  input  logic [XLEN-1:0]              redirect_pc,
  instruction_prefetch_if.master       bus,
  output logic                         busy
`ifdef IFETCH_STATS_EN
  ,
  output logic [31:0]                  stat_fetch_cnt,
  output logic [31:0]                  stat_drop_cnt
`endif
);

  localparam int unsigned CW = $clog2(QDEPTH + 1);
  localparam int unsigned AW = $clog2(QDEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     insn;
  } entry_t;

  state_t          state_q;
  state_t          state_d;
  logic [XLEN-1:0] fetch_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop;
  logic [CW-1:0]   count;
  logic [AW-1:0]   head;
  logic [AW-1:0]   tail;
  logic [AW-1:0]   pc_wr;
  logic [AW-1:0]   pc_rd;
  entry_t          q_mem  [QDEPTH];
  logic [XLEN-1:0] pc_mem [QDEPTH];

  logic [CW:0]     credit_used;
  logic            req_valid_c;
  logic            req_fire;
  logic            rsp_take;
  logic            rsp_drop;
  logic            push;
  logic            pop;
  logic [XLEN-1:0] redirect_aligned;

  // Credit accounting and per-cycle event decode
  assign credit_used      = {1'b0, outstanding} + {1'b0, count};
  assign req_fire         = req_valid_c && bus.imem_req_ready;
  assign rsp_take         = bus.imem_rsp_valid && (outstanding != '0);
  assign rsp_drop         = rsp_take && (redirect_en || (drop != '0));
  assign push             = rsp_take && !rsp_drop;
  assign pop              = (count != '0) && bus.out_ready && !redirect_en;
  assign redirect_aligned = redirect_pc & ~XLEN'(3);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and request-valid decode
  always_comb begin
    state_d     = state_q;
    req_valid_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (run) state_d = RUN;
      end
      RUN: begin
        req_valid_c = (credit_used < (CW + 1)'(QDEPTH)) && !redirect_en;
        if (!run) state_d = DRAIN;
      end
      DRAIN: begin
        if (run) begin
          state_d = RUN;
        end else if (outstanding == '0) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Fetch PC, in-flight and discard counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc    <= START_ADDR;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      outstanding <= outstanding + CW'(req_fire) - CW'(rsp_take);
      if (redirect_en) begin
        fetch_pc <= redirect_aligned;
        drop     <= outstanding - CW'(rsp_take);
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
        if (rsp_take && (drop != '0)) drop <= drop - CW'(1);
      end
    end
  end

  // Queue and PC-tag FIFO pointers; redirect flushes both
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      pc_wr <= '0;
      pc_rd <= '0;
    end else if (redirect_en) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      pc_wr <= '0;
      pc_rd <= '0;
    end else begin
      if (push)     tail  <= tail + AW'(1);
      if (pop)      head  <= head + AW'(1);
      if (req_fire) pc_wr <= pc_wr + AW'(1);
      if (push)     pc_rd <= pc_rd + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Queue and PC-tag storage; cleared on reset so the idle head reads zero
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < QDEPTH; i++) begin
        q_mem[i]  <= '0;
        pc_mem[i] <= '0;
      end
    end else if (!redirect_en) begin
      if (req_fire) pc_mem[pc_wr] <= fetch_pc;
      if (push) begin
        q_mem[tail].pc   <= pc_mem[pc_rd];
        q_mem[tail].insn <= bus.imem_rsp_data;
      end
    end
  end

`ifdef IFETCH_STATS_EN
  // Saturating statistics: instructions handed to decode, responses discarded
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_fetch_cnt <= '0;
      stat_drop_cnt  <= '0;
    end else begin
      if (pop && (stat_fetch_cnt != '1))     stat_fetch_cnt <= stat_fetch_cnt + 32'd1;
      if (rsp_drop && (stat_drop_cnt != '1)) stat_drop_cnt  <= stat_drop_cnt + 32'd1;
    end
  end
`endif

  // Output drive
  assign bus.imem_req_valid = req_valid_c;
  assign bus.imem_req_addr  = fetch_pc;
  assign bus.out_valid      = (count != '0);
  assign bus.out_pc         = q_mem[head].pc;
  assign bus.out_insn       = q_mem[head].insn;
  assign busy               = (outstanding != '0) || (count != '0);

endmodule

// File: tb/tb_instruction_prefetch.sv
// Directed bench for instruction_prefetch: a per-cycle vector table for the
// steady fetch/drain/resume flow, then hand-written multi-cycle sequences for
// backpressure, redirect, drain with outstanding requests and mid-run reset.
module tb_instruction_prefetch;

  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            run;
  logic            redirect_en;
  logic [XLEN-1:0] redirect_pc;
  logic            busy;
`ifdef IFETCH_STATS_EN
  logic [31:0]     stat_fetch_cnt;
  logic [31:0]     stat_drop_cnt;
`endif

  instruction_prefetch_if #(.XLEN(XLEN)) bus_if ();

  instruction_prefetch #(
    .XLEN       (XLEN),
    .START_ADDR (32'h8000_0000),
    .QDEPTH     (4)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .run            (run),
    .redirect_en    (redirect_en),
    .redirect_pc    (redirect_pc),
    .bus            (bus_if),
    .busy           (busy)
`ifdef IFETCH_STATS_EN
    ,
    .stat_fetch_cnt (stat_fetch_cnt),
    .stat_drop_cnt  (stat_drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        run;
    logic        rsp_v;
    logic [31:0] rsp_d;
    logic        req_v;
    logic [31:0] addr;
    logic        out_v;
    logic [31:0] pc;
    logic [31:0] insn;
    logic        busy;
  } vec_t;

  vec_t        tbl [15];
  int          checks;
  int          failures;
  int          hs_cnt;
  logic        mem_auto;
  logic        rsp_en;
  logic [31:0] pend [$];

  function automatic logic [31:0] insn_of(input logic [31:0] a);
    return {a[15:0], 16'h0013};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: record handshakes at the falling edge, then let the memory model answer
  task automatic tick();
    logic        hs;
    logic [31:0] a;
    @(negedge clk);
    hs = bus_if.imem_req_valid && bus_if.imem_req_ready;
    a  = bus_if.imem_req_addr;
    if (hs) begin
      pend.push_back(a);
      hs_cnt++;
    end
    @(posedge clk);
    #1;
    if (mem_auto) begin
      if (rsp_en && (pend.size() > 0)) begin
        bus_if.imem_rsp_valid = 1'b1;
        bus_if.imem_rsp_data  = insn_of(pend.pop_front());
      end else begin
        bus_if.imem_rsp_valid = 1'b0;
        bus_if.imem_rsp_data  = '0;
      end
    end
  endtask

  task automatic do_reset();
    reset_n               = 1'b0;
    run                   = 1'b0;
    redirect_en           = 1'b0;
    redirect_pc           = '0;
    bus_if.imem_req_ready = 1'b1;
    bus_if.imem_rsp_valid = 1'b0;
    bus_if.imem_rsp_data  = '0;
    bus_if.out_ready      = 1'b1;
    mem_auto              = 1'b0;
    rsp_en                = 1'b0;
    pend.delete();
    hs_cnt                = 0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    checks   = 0;
    failures = 0;

    // run, rsp_v, rsp_d, | req_v, addr, out_v, pc, insn, busy
    tbl[0]  = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h8000_0000, 1'b0, 32'h0,         32'h0,         1'b0};
    tbl[1]  = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h8000_0000, 1'b0, 32'h0,         32'h0,         1'b0};
    tbl[2]  = '{1'b1, 1'b1, 32'h0000_0013, 1'b1, 32'h8000_0004, 1'b0, 32'h0,         32'h0,         1'b1};
    tbl[3]  = '{1'b1, 1'b1, 32'h0004_0013, 1'b1, 32'h8000_0008, 1'b1, 32'h8000_0000, 32'h0000_0013, 1'b1};
    tbl[4]  = '{1'b1, 1'b1, 32'h0008_0013, 1'b1, 32'h8000_000C, 1'b1, 32'h8000_0004, 32'h0004_0013, 1'b1};
    tbl[5]  = '{1'b0, 1'b1, 32'h000C_0013, 1'b1, 32'h8000_0010, 1'b1, 32'h8000_0008, 32'h0008_0013, 1'b1};
    tbl[6]  = '{1'b0, 1'b1, 32'h0010_0013, 1'b0, 32'h8000_0014, 1'b1, 32'h8000_000C, 32'h000C_0013, 1'b1};
    tbl[7]  = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h8000_0014, 1'b1, 32'h8000_0010, 32'h0010_0013, 1'b1};
    tbl[8]  = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h8000_0014, 1'b0, 32'h0,         32'h0,         1'b0};
    tbl[9]  = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h8000_0014, 1'b0, 32'h0,         32'h0,         1'b0};
    tbl[10] = '{1'b1, 1'b1, 32'h0014_0013, 1'b1, 32'h8000_0018, 1'b0, 32'h0,         32'h0,         1'b1};
    tbl[11] = '{1'b0, 1'b1, 32'h0018_0013, 1'b1, 32'h8000_001C, 1'b1, 32'h8000_0014, 32'h0014_0013, 1'b1};
    tbl[12] = '{1'b0, 1'b1, 32'h001C_0013, 1'b0, 32'h8000_0020, 1'b1, 32'h8000_0018, 32'h0018_0013, 1'b1};
    tbl[13] = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h8000_0020, 1'b1, 32'h8000_001C, 32'h001C_0013, 1'b1};
    tbl[14] = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h8000_0020, 1'b0, 32'h0,         32'h0,         1'b0};

    // Zero-wait stream, run drop/drain, resume at next sequential PC
    do_reset();
    for (int i = 0; i < 15; i++) begin
      run                   = tbl[i].run;
      bus_if.imem_rsp_valid = tbl[i].rsp_v;
      bus_if.imem_rsp_data  = tbl[i].rsp_d;
      #1;
      chk($sformatf("t%0d req_valid", i), 32'(bus_if.imem_req_valid), 32'(tbl[i].req_v));
      chk($sformatf("t%0d req_addr", i),  bus_if.imem_req_addr,        tbl[i].addr);
      chk($sformatf("t%0d out_valid", i), 32'(bus_if.out_valid),       32'(tbl[i].out_v));
      chk($sformatf("t%0d busy", i),      32'(busy),                   32'(tbl[i].busy));
      if (tbl[i].out_v || (i == 0)) begin
        chk($sformatf("t%0d out_pc", i),   bus_if.out_pc,   tbl[i].pc);
        chk($sformatf("t%0d out_insn", i), bus_if.out_insn, tbl[i].insn);
      end
      tick();
    end
`ifdef IFETCH_STATS_EN
    chk("tbl stat_fetch_cnt", stat_fetch_cnt, 32'd8);
`endif

    // Backpressure: queue fills to QDEPTH, issue resumes one cycle after a pop
    do_reset();
    run = 1'b1; bus_if.out_ready = 1'b0; mem_auto = 1'b1; rsp_en = 1'b1;
    repeat (12) tick();
    #1;
    chk("bp handshakes", 32'(hs_cnt), 32'd4);
    chk("bp req_valid full", 32'(bus_if.imem_req_valid), 32'd0);
    chk("bp out_valid", 32'(bus_if.out_valid), 32'd1);
    chk("bp out_pc head", bus_if.out_pc, 32'h8000_0000);
    bus_if.out_ready = 1'b1;
    #1;
    chk("bp req_valid pop cycle", 32'(bus_if.imem_req_valid), 32'd0);
    tick();
    #1;
    chk("bp req_valid resume", 32'(bus_if.imem_req_valid), 32'd1);
    chk("bp req_addr resume", bus_if.imem_req_addr, 32'h8000_0010);
    chk("bp out_pc next", bus_if.out_pc, 32'h8000_0004);

    // Redirect with three requests in flight
    do_reset();
    run = 1'b1; mem_auto = 1'b1; rsp_en = 1'b0;
    repeat (4) tick();
    redirect_en = 1'b1; redirect_pc = 32'h8000_0103;
    #1;
    chk("rd req_valid in redirect", 32'(bus_if.imem_req_valid), 32'd0);
    tick();
    redirect_en = 1'b0; rsp_en = 1'b1;
    #1;
    chk("rd req_valid after", 32'(bus_if.imem_req_valid), 32'd1);
    chk("rd req_addr after", bus_if.imem_req_addr, 32'h8000_0100);
    tick();
    n = 0;
    while (!bus_if.out_valid && (n < 20)) begin
      tick();
      n++;
    end
    chk("rd wait cycles", 32'(n), 32'd4);
    chk("rd out_pc", bus_if.out_pc, 32'h8000_0100);
    chk("rd out_insn", bus_if.out_insn, 32'h0100_0013);
`ifdef IFETCH_STATS_EN
    chk("rd stat_drop_cnt", stat_drop_cnt, 32'd3);
`endif

    // Redirect coinciding with a response and a pop
    do_reset();
    run = 1'b1; bus_if.out_ready = 1'b1;
    tick();
    tick();
    bus_if.imem_rsp_valid = 1'b1; bus_if.imem_rsp_data = insn_of(32'h8000_0000);
    tick();
    bus_if.imem_rsp_valid = 1'b0; bus_if.out_ready = 1'b0;
    #1;
    chk("rp out_valid pre", 32'(bus_if.out_valid), 32'd1);
    tick();
    tick();
    redirect_en = 1'b1; redirect_pc = 32'h8000_0200; bus_if.out_ready = 1'b1;
    bus_if.imem_rsp_valid = 1'b1; bus_if.imem_rsp_data = insn_of(32'h8000_0004);
    #1;
    chk("rp req_valid redirect", 32'(bus_if.imem_req_valid), 32'd0);
    chk("rp out_pc redirect", bus_if.out_pc, 32'h8000_0000);
    tick();
    redirect_en = 1'b0; bus_if.imem_rsp_valid = 1'b0; run = 1'b0;
    #1;
    chk("rp out_valid flushed", 32'(bus_if.out_valid), 32'd0);
    chk("rp busy", 32'(busy), 32'd1);
    chk("rp req_valid", 32'(bus_if.imem_req_valid), 32'd1);
    chk("rp req_addr", bus_if.imem_req_addr, 32'h8000_0200);
    tick();
    bus_if.imem_rsp_valid = 1'b1; bus_if.imem_rsp_data = insn_of(32'h8000_0008);
    #1;
    chk("rp req_valid drain", 32'(bus_if.imem_req_valid), 32'd0);
    chk("rp out_valid drop1", 32'(bus_if.out_valid), 32'd0);
    tick();
    bus_if.imem_rsp_data = insn_of(32'h8000_000C);
    #1;
    chk("rp out_valid drop2", 32'(bus_if.out_valid), 32'd0);
    tick();
    bus_if.imem_rsp_data = insn_of(32'h8000_0200);
    #1;
    chk("rp out_valid drop3", 32'(bus_if.out_valid), 32'd0);
    tick();
    bus_if.imem_rsp_valid = 1'b0;
    #1;
    chk("rp out_valid new", 32'(bus_if.out_valid), 32'd1);
    chk("rp out_pc new", bus_if.out_pc, 32'h8000_0200);
    chk("rp out_insn new", bus_if.out_insn, 32'h0200_0013);
`ifdef IFETCH_STATS_EN
    chk("rp stat_drop_cnt", stat_drop_cnt, 32'd3);
`endif
    tick();
    #1;
    chk("rp busy idle", 32'(busy), 32'd0);
`ifdef IFETCH_STATS_EN
    chk("rp stat_fetch_cnt", stat_fetch_cnt, 32'd1);
`endif

    // run dropped with two outstanding, then resume
    do_reset();
    run = 1'b1; bus_if.out_ready = 1'b1;
    tick();
    tick();
    run = 1'b0;
    #1;
    chk("dr req_addr last", bus_if.imem_req_addr, 32'h8000_0004);
    tick();
    bus_if.imem_rsp_valid = 1'b1; bus_if.imem_rsp_data = insn_of(32'h8000_0000);
    #1;
    chk("dr req_valid off", 32'(bus_if.imem_req_valid), 32'd0);
    chk("dr busy out2", 32'(busy), 32'd1);
    tick();
    bus_if.imem_rsp_data = insn_of(32'h8000_0004); bus_if.out_ready = 1'b0;
    #1;
    chk("dr out_pc first", bus_if.out_pc, 32'h8000_0000);
    tick();
    bus_if.imem_rsp_valid = 1'b0;
    #1;
    chk("dr req_valid still off", 32'(bus_if.imem_req_valid), 32'd0);
    chk("dr busy queued", 32'(busy), 32'd1);
    tick();
    bus_if.out_ready = 1'b1;
    #1;
    chk("dr busy idle queued", 32'(busy), 32'd1);
    tick();
    #1;
    chk("dr out_pc second", bus_if.out_pc, 32'h8000_0004);
    chk("dr out_insn second", bus_if.out_insn, 32'h0004_0013);
    tick();
    #1;
    chk("dr busy drained", 32'(busy), 32'd0);
    run = 1'b1;
    tick();
    #1;
    chk("dr req_valid resume", 32'(bus_if.imem_req_valid), 32'd1);
    chk("dr req_addr resume", bus_if.imem_req_addr, 32'h8000_0008);

    // Asynchronous reset mid-burst; late response after release is ignored
    do_reset();
    run = 1'b1; mem_auto = 1'b1; rsp_en = 1'b1;
    repeat (6) tick();
    reset_n = 1'b0;
    #1;
    chk("rs req_valid", 32'(bus_if.imem_req_valid), 32'd0);
    chk("rs req_addr", bus_if.imem_req_addr, 32'h8000_0000);
    chk("rs out_valid", 32'(bus_if.out_valid), 32'd0);
    chk("rs out_pc", bus_if.out_pc, 32'h0);
    chk("rs out_insn", bus_if.out_insn, 32'h0);
    chk("rs busy", 32'(busy), 32'd0);
    mem_auto = 1'b0; run = 1'b0;
    bus_if.imem_rsp_valid = 1'b1; bus_if.imem_rsp_data = 32'hDEAD_BEEF;
    tick();
    reset_n = 1'b1;
    tick();
    bus_if.imem_rsp_valid = 1'b0;
    #1;
    chk("rs stray out_valid", 32'(bus_if.out_valid), 32'd0);
    chk("rs stray busy", 32'(busy), 32'd0);
    run = 1'b1;
    tick();
    #1;
    chk("rs restart valid", 32'(bus_if.imem_req_valid), 32'd1);
    chk("rs restart addr", bus_if.imem_req_addr, 32'h8000_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
